// File: rtl/hamming_tx_ctrl.sv
// hamming_tx_ctrl
// Transmit-side sequencer for an external (7,4) Hamming encoder with an
// overall-parity bit. Bytes arrive over a valid/ready handshake. Each byte
// is split into a high and a low nibble. Each nibble is driven into the
// encoder, and the 7-bit codeword plus parity is captured as one 8-bit
// symbol. Symbols are shifted out MSB-first on a single line, and every
// frame is preceded by an 8-bit preamble.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_data     byte to transmit
//   in_valid    in_data is valid
//   in_ready    byte is accepted this cycle (decoded from state only)
//   enc_nibble  registered nibble into the encoder (index 0 = MSB)
//   enc_code    encoder codeword (index 0 = MSB, sent first)
//   enc_parity  encoder overall parity
//   tx_bit      serial line data
//   tx_en       tx_bit carries a line bit
//   busy        frame in progress
//   frame_done  one-cycle pulse after the last bit of a frame
//   underrun    sticky: the source left LOAD waiting; cleared by reset only
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for in_valid to open a frame
// PRE     | shifting out the preamble
// LOAD    | in_ready high, waiting for the next byte
// ENC_HI  | encoder settling on the high nibble, capture symbol
// SEND_HI | shifting out the high-nibble symbol
// ENC_LO  | encoder settling on the low nibble, capture symbol
// SEND_LO | shifting out the low-nibble symbol
// DONE    | frame_done pulse, back to IDLE

module hamming_tx_ctrl #(
  parameter int unsigned PKT_BYTES = 4,
  parameter int unsigned BIT_DIV   = 4,
  parameter logic [7:0]  PREAMBLE  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [0:3] enc_nibble,
  input  logic [0:6] enc_code,
  input  logic       enc_parity,
  output logic       tx_bit,
  output logic       tx_en,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LOAD,
    S_ENC_HI,
    S_SEND_HI,
    S_ENC_LO,
    S_SEND_LO,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(BIT_DIV - 1);
  localparam logic [7:0] BYTE_LAST = 8'(PKT_BYTES - 1);

  state_t     state;
  logic [7:0] shreg;
  logic [7:0] byte_reg;
  logic [7:0] div_cnt;
  logic [7:0] byte_cnt;
  logic [2:0] bit_cnt;
  logic       load_wait;  // set once LOAD has already lasted one cycle
  logic       shifting;

  assign shifting   = (state == S_PRE) || (state == S_SEND_HI) || (state == S_SEND_LO);

  // All outputs are decoded from registered state only, so none of them
  // has a combinational path from an input.
  assign tx_en      = shifting;
  assign tx_bit     = shifting & shreg[7];
  assign in_ready   = (state == S_LOAD);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      byte_reg   <= '0;
      div_cnt    <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      load_wait  <= 1'b0;
      enc_nibble <= '0;
      underrun   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg    <= PREAMBLE;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            byte_cnt <= '0;
            state    <= S_PRE;
          end
        end

        S_PRE, S_SEND_HI, S_SEND_LO: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;  // wraps to 0 after the eighth bit
            if (bit_cnt == 3'd7) begin
              case (state)
                S_PRE: begin
                  load_wait <= 1'b0;
                  state     <= S_LOAD;
                end
                S_SEND_HI: begin
                  enc_nibble <= byte_reg[3:0];
                  state      <= S_ENC_LO;
                end
                default: begin
                  if (byte_cnt == BYTE_LAST) begin
                    state <= S_DONE;
                  end else begin
                    byte_cnt  <= byte_cnt + 8'd1;
                    load_wait <= 1'b0;
                    state     <= S_LOAD;
                  end
                end
              endcase
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        S_LOAD: begin
          // Any cycle in LOAD after the first means the source starved the line.
          if (load_wait) begin
            underrun <= 1'b1;
          end
          if (in_valid) begin
            byte_reg   <= in_data;
            enc_nibble <= in_data[7:4];
            state      <= S_ENC_HI;
          end else begin
            load_wait <= 1'b1;
          end
        end

        S_ENC_HI: begin
          shreg <= {enc_code, enc_parity};
          state <= S_SEND_HI;
        end

        S_ENC_LO: begin
          shreg <= {enc_code, enc_parity};
          state <= S_SEND_LO;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_tx_ctrl.sv
// Testbench for hamming_tx_ctrl. Two instances are used: one with
// PKT_BYTES=1/BIT_DIV=1 and one with PKT_BYTES=4/BIT_DIV=4. Each instance
// has a stub encoder: code = {nibble, 3'b101}, parity = ^nibble.
module tb_hamming_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] in_data;
  logic       src_valid;
  logic       sel;  // 0: instance a, 1: instance b

  logic       a_valid, a_ready, a_par, a_bit, a_en, a_busy, a_done, a_unr;
  logic [0:3] a_nib;
  logic [0:6] a_code;
  logic       b_valid, b_ready, b_par, b_bit, b_en, b_busy, b_done, b_unr;
  logic [0:3] b_nib;
  logic [0:6] b_code;

  assign a_valid = src_valid & ~sel;
  assign b_valid = src_valid & sel;
  assign a_code  = {a_nib, 3'b101};
  assign a_par   = ^a_nib;
  assign b_code  = {b_nib, 3'b101};
  assign b_par   = ^b_nib;

  hamming_tx_ctrl #(.PKT_BYTES(1), .BIT_DIV(1), .PREAMBLE(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(a_valid), .in_ready(a_ready),
    .enc_nibble(a_nib), .enc_code(a_code), .enc_parity(a_par), .tx_bit(a_bit),
    .tx_en(a_en), .busy(a_busy), .frame_done(a_done), .underrun(a_unr));

  hamming_tx_ctrl #(.PKT_BYTES(4), .BIT_DIV(4), .PREAMBLE(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(b_valid), .in_ready(b_ready),
    .enc_nibble(b_nib), .enc_code(b_code), .enc_parity(b_par), .tx_bit(b_bit),
    .tx_en(b_en), .busy(b_busy), .frame_done(b_done), .underrun(b_unr));

  logic m_ready, m_bit, m_en, m_busy, m_done, m_unr;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_bit   = sel ? b_bit   : a_bit;
  assign m_en    = sel ? b_en    : a_en;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_unr   = sel ? b_unr   : a_unr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed symbols per byte for the stub encoder.
  typedef struct {
    logic [7:0] data;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] exp_q[$];
  logic [7:0] sym_q[$];
  logic [7:0] src_q[$];
  logic [7:0] acc_log[$];
  logic       src_en;
  logic       take;
  int         n_done;

  // Byte source: drives valid/data after the edge and pops accepted bytes.
  always begin
    @(negedge clk);
    take = src_valid && m_ready && rst_n;
    @(posedge clk);
    #2;
    if (take && src_q.size() > 0) acc_log.push_back(src_q.pop_front());
    src_valid = src_en && (src_q.size() > 0);
    in_data   = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // Line monitor: each tx_en run must be 8 bits, each held BIT_DIV cycles.
  logic run[$];
  always @(negedge clk) begin
    int bd;
    logic ok;
    logic [7:0] sym;
    if (!rst_n) begin
      run.delete();
    end else if (m_en) begin
      run.push_back(m_bit);
    end else if (run.size() > 0) begin
      bd  = sel ? 4 : 1;
      ok  = (run.size() == 8 * bd);
      sym = '0;
      if (ok) begin
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < bd; j++) if (run[i*bd+j] !== run[i*bd]) ok = 1'b0;
          sym = {sym[6:0], run[i*bd]};
        end
      end
      check("bit_hold", {31'd0, ok}, 32'd1);
      sym_q.push_back(sym);
      run.delete();
    end
    if (rst_n && m_done) n_done++;
  end

  task automatic add_byte(input int v);
    exp_q.push_back(vecs[v].hi);
    exp_q.push_back(vecs[v].lo);
  endtask

  task automatic check_syms(input string tag);
    check({tag, "_count"}, sym_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < sym_q.size()) check(tag, {24'd0, sym_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic clear_logs();
    sym_q.delete();
    exp_q.delete();
    acc_log.delete();
    n_done = 0;
    exp_q.push_back(8'hA5);
  endtask

  // idx 0 is the IDLE cycle in which in_valid is first seen.
  task automatic run_frame(input int limit, output int idx);
    idx = 0;
    @(negedge clk);
    while (!m_done && idx < limit) begin
      @(negedge clk);
      idx++;
    end
    check("frame_done_seen", {31'd0, m_done}, 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    @(negedge clk);
    while (!m_done && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("frame_done_seen", {31'd0, m_done}, 32'd1);
  endtask

  initial begin
    int   idx, cnt, acc_base;
    logic any, gap_en, gap_rdy;

    vecs[0] = '{8'h3C, 8'h3A, 8'hCA};
    vecs[1] = '{8'h00, 8'h0A, 8'h0A};
    vecs[2] = '{8'hFF, 8'hFA, 8'hFA};
    vecs[3] = '{8'h5A, 8'h5A, 8'hAA};
    vecs[4] = '{8'hA5, 8'hAA, 8'h5A};
    vecs[5] = '{8'h17, 8'h1B, 8'h7B};

    rst_n = 1'b0; src_en = 1'b0; sel = 1'b0; src_valid = 1'b0; in_data = 8'h00;
    n_done = 0;

    // Reset state
    @(posedge clk); #1;
    check("reset_outs_a", {a_en, a_bit, a_busy, a_ready, a_done, a_unr, a_nib}, 0);
    check("reset_outs_b", {b_en, b_bit, b_busy, b_ready, b_done, b_unr, b_nib}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    any = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any |= a_en | a_ready | a_busy | a_done | b_en | b_ready | b_busy | b_done;
    end
    check("idle_after_reset", {31'd0, any}, 0);

    // Single byte, BIT_DIV=1
    clear_logs();
    add_byte(0);
    @(posedge clk); #1;
    src_q.push_back(8'h3C);
    src_en = 1'b1;
    run_frame(100, idx);
    check("a_frame_len", idx, 28);
    repeat (2) @(negedge clk);
    check_syms("a_sym");
    check("a_accepts", acc_log.size(), 1);
    check("a_dones", n_done, 1);
    check("a_underrun", {31'd0, a_unr}, 0);
    @(posedge clk); #1 src_en = 1'b0;

    // Two frames back-to-back on instance a
    clear_logs();
    add_byte(5);
    exp_q.push_back(8'hA5);
    add_byte(3);
    @(posedge clk); #1;
    src_q.push_back(8'h17);
    src_q.push_back(8'h5A);
    src_en = 1'b1;
    run_frame(100, idx);
    check("b2b_len1", idx, 28);
    @(negedge clk);
    check("b2b_idle_gap", {30'd0, a_busy, a_en}, 0);
    @(negedge clk);
    check("b2b_pre_start", {30'd0, a_busy, a_en}, 3);
    wait_done(60);
    repeat (2) @(negedge clk);
    check_syms("b2b_sym");
    check("b2b_dones", n_done, 2);
    check("b2b_accepts", acc_log.size(), 2);
    if (acc_log.size() == 2) check("b2b_order", {acc_log[0], acc_log[1]}, 16'h175A);
    check("b2b_underrun", {31'd0, a_unr}, 0);
    @(posedge clk); #1 src_en = 1'b0;

    // Full frame, PKT_BYTES=4, BIT_DIV=4
    sel = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    for (int v = 1; v <= 4; v++) add_byte(v);
    @(posedge clk); #1;
    for (int v = 1; v <= 4; v++) src_q.push_back(vecs[v].data);
    src_en = 1'b1;
    run_frame(400, idx);
    check("b_frame_len", idx, 301);
    repeat (2) @(negedge clk);
    check_syms("b_sym");
    check("b_accepts", acc_log.size(), 4);
    check("b_underrun", {31'd0, b_unr}, 0);
    @(posedge clk); #1 src_en = 1'b0;

    // Starved source before the second byte
    clear_logs();
    for (int v = 1; v <= 4; v++) add_byte(v);
    @(posedge clk); #1;
    src_q.push_back(8'h00);
    src_en = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(acc_log.size() == 1 && m_ready) && cnt < 500);
    check("starve_reach_load", {31'd0, m_ready}, 1);
    gap_en = 1'b0; gap_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      gap_en  |= m_en;
      gap_rdy &= m_ready;
      if (k < 9) @(negedge clk);
    end
    check("starve_tx_en_gap", {31'd0, gap_en}, 0);
    check("starve_ready_gap", {31'd0, gap_rdy}, 1);
    check("starve_underrun", {31'd0, m_unr}, 1);
    @(posedge clk); #1;
    for (int v = 2; v <= 4; v++) src_q.push_back(vecs[v].data);
    wait_done(400);
    repeat (5) @(negedge clk);
    check_syms("starve_sym");
    check("starve_dones", n_done, 1);
    check("starve_underrun_sticky", {31'd0, m_unr}, 1);
    @(posedge clk); #1 src_en = 1'b0;

    // Asynchronous reset during SEND_LO of the first byte
    clear_logs();
    @(posedge clk); #1;
    src_q.push_back(8'h17);
    src_q.push_back(8'h3C);
    for (int v = 1; v <= 3; v++) src_q.push_back(vecs[v].data);
    src_en = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(sym_q.size() == 2 && m_en) && cnt < 500);
    check("rst_reach_send_lo", {31'd0, m_en}, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_outs_zero", {b_en, b_bit, b_busy, b_ready, b_done, b_unr, b_nib}, 0);
    check("rst_no_done", n_done, 0);
    repeat (2) @(posedge clk);
    #1;
    sym_q.delete();
    acc_base = acc_log.size();
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int v = 0; v <= 3; v++) add_byte(v);
    wait_done(400);
    repeat (2) @(negedge clk);
    check_syms("rst_sym");
    check("rst_dones", n_done, 1);
    check("rst_accepts", acc_log.size() - acc_base, 4);
    if (acc_log.size() > acc_base) check("rst_first_byte", {24'd0, acc_log[acc_base]}, 32'h3C);
    @(posedge clk); #1 src_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
